// File: rtl/window_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// window_fetch_sequencer
//
// Walks every interior pixel of an IMG_W x IMG_H frame in raster order. For
// each one it reads the 3x3 neighbourhood from a synchronous frame memory
// (one read per cycle, nine reads), then presents the window to the sharpening
// pipeline and holds it until win_valid & win_ready.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-low
//   start               begin a full-frame pass (sampled only in IDLE or DONE)
//   rd_en, rd_addr      registered frame-memory read strobe / word address
//   rd_data             memory data, valid the cycle after rd_en was sampled
//   win0..win8          3x3 window, row-major, win4 = centre pixel
//   win_row, win_col    centre-pixel coordinates of the window
//   win_valid/win_ready window handshake
//   busy                high while fetching or presenting
//   halt                frame complete (DONE state)
// -----------------------------------------------------------------------------
module window_fetch_sequencer #(
  parameter int IMG_W = 800,
  parameter int IMG_H = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_en,
  output logic [18:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  win0,
  output logic [7:0]  win1,
  output logic [7:0]  win2,
  output logic [7:0]  win3,
  output logic [7:0]  win4,
  output logic [7:0]  win5,
  output logic [7:0]  win6,
  output logic [7:0]  win7,
  output logic [7:0]  win8,
  output logic [9:0]  win_row,
  output logic [9:0]  win_col,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        busy,
  output logic        halt
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [9:0]  LAST_COL = 10'(IMG_W - 2);
  localparam logic [9:0]  LAST_ROW = 10'(IMG_H - 2);
  // Jump from the third pixel of one window row to the first of the next.
  localparam logic [18:0] ROW_STEP = 19'(IMG_W - 2);

  state_t          state;
  logic [8:0][7:0] win_q;
  logic [18:0]     base;     // address of the window's top-left pixel
  logic [3:0]      cnt;      // FETCH cycle counter, 0..9
  logic [1:0]      sub;      // column within the current window row, 0..2

  logic            last_col;
  logic            last_win;
  logic [18:0]     base_next;

  assign last_col  = (win_col == LAST_COL);
  assign last_win  = last_col && (win_row == LAST_ROW);
  // Next window: one column right, or (at row wrap) skip the two border
  // pixels at the end of this row and the one at the start of the next.
  assign base_next = base + (last_col ? 19'd3 : 19'd1);

  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      // NOTE: the window registers are reset too, because every output must
      // read 0 while reset is asserted.
      win_q     <= '0;
      win_row   <= '0;
      win_col   <= '0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      halt      <= 1'b0;
      base      <= '0;
      cnt       <= '0;
      sub       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= FETCH;
            win_row <= 10'd1;
            win_col <= 10'd1;
            halt    <= 1'b0;
            busy    <= 1'b1;
            base    <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            cnt     <= '0;
            sub     <= '0;
          end
        end

        FETCH: begin
          cnt <= cnt + 4'd1;
          // Data for read k arrives while cnt == k+1.
          if (cnt != 4'd0) win_q[cnt - 4'd1] <= rd_data;
          if (cnt < 4'd8) begin
            rd_addr <= rd_addr + ((sub == 2'd2) ? ROW_STEP : 19'd1);
            sub     <= (sub == 2'd2) ? 2'd0 : sub + 2'd1;
          end
          if (cnt == 4'd8) rd_en <= 1'b0;
          if (cnt == 4'd9) begin
            state     <= PRESENT;
            win_valid <= 1'b1;
          end
        end

        PRESENT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_win) begin
              state <= DONE;
              halt  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= FETCH;
              base    <= base_next;
              rd_addr <= base_next;
              rd_en   <= 1'b1;
              cnt     <= '0;
              sub     <= '0;
              if (last_col) begin
                win_col <= 10'd1;
                win_row <= win_row + 10'd1;
              end else begin
                win_col <= win_col + 10'd1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for window_fetch_sequencer.
//   dut_a: 4x4 frame, directed window table plus stall / tied-ready / reset
//          sequences.
//   dut_b: 800x4 frame, ready tied high, streaming address and window model,
//          two complete passes.
// Both memories return the low byte of the word address.
// -----------------------------------------------------------------------------
module tb_window_fetch_sequencer;

  localparam int AW = 4;
  localparam int BW = 800;
  localparam int BH = 4;
  localparam int B_WINS = (BW - 2) * (BH - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- dut_a
  logic        reset_a, start_a, ready_a;
  logic        rd_en_a, win_valid_a, busy_a, halt_a;
  logic [18:0] rd_addr_a;
  logic [7:0]  rd_data_a;
  logic [7:0]  wa [9];
  logic [9:0]  win_row_a, win_col_a;

  window_fetch_sequencer #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .win0(wa[0]), .win1(wa[1]), .win2(wa[2]), .win3(wa[3]), .win4(wa[4]),
    .win5(wa[5]), .win6(wa[6]), .win7(wa[7]), .win8(wa[8]),
    .win_row(win_row_a), .win_col(win_col_a), .win_valid(win_valid_a),
    .win_ready(ready_a), .busy(busy_a), .halt(halt_a)
  );

  always @(posedge clk) if (rd_en_a) rd_data_a <= rd_addr_a[7:0];

  // ---------------------------------------------------------------- dut_b
  logic        reset_b, start_b, ready_b;
  logic        rd_en_b, win_valid_b, busy_b, halt_b;
  logic [18:0] rd_addr_b;
  logic [7:0]  rd_data_b;
  logic [7:0]  wb [9];
  logic [9:0]  win_row_b, win_col_b;

  window_fetch_sequencer #(.IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .win0(wb[0]), .win1(wb[1]), .win2(wb[2]), .win3(wb[3]), .win4(wb[4]),
    .win5(wb[5]), .win6(wb[6]), .win7(wb[7]), .win8(wb[8]),
    .win_row(win_row_b), .win_col(win_col_b), .win_valid(win_valid_b),
    .win_ready(ready_b), .busy(busy_b), .halt(halt_b)
  );

  always @(posedge clk) if (rd_en_b) rd_data_b <= rd_addr_b[7:0];

  // ------------------------------------------------------------- monitors
  // Sampled 3 time units after each rising edge; the main thread drives
  // inputs at +1 and at the falling edge, so the two never collide.
  int          rd_cnt_a = 0;
  logic [18:0] qa [$];
  int          hs_r [$];
  int          hs_c [$];

  always @(posedge clk) begin
    #3;
    if (rd_en_a) begin
      rd_cnt_a++;
      qa.push_back(rd_addr_a);
    end
    if (win_valid_a && ready_a) begin
      hs_r.push_back(int'(win_row_a));
      hs_c.push_back(int'(win_col_a));
    end
  end

  function automatic int baddr(input int r, input int c, input int k);
    return (r - 1 + k / 3) * BW + (c - 1) + (k % 3);
  endfunction

  int rd_cnt_b = 0, hs_cnt_b = 0, addr_err_b = 0, win_err_b = 0, last_addr_b = 0;
  int ba_r = 1, ba_c = 1, ba_k = 0;
  int bw_r = 1, bw_c = 1;

  always @(posedge clk) begin
    #3;
    if (rd_en_b) begin
      rd_cnt_b++;
      last_addr_b = int'(rd_addr_b);
      if (int'(rd_addr_b) != baddr(ba_r, ba_c, ba_k)) addr_err_b++;
      if (ba_k == 8) begin
        ba_k = 0;
        if (ba_c == BW - 2) begin
          ba_c = 1;
          ba_r = (ba_r == BH - 2) ? 1 : ba_r + 1;
        end else ba_c++;
      end else ba_k++;
    end
    if (win_valid_b && ready_b) begin
      hs_cnt_b++;
      if (int'(win_row_b) != bw_r || int'(win_col_b) != bw_c) win_err_b++;
      for (int k = 0; k < 9; k++)
        if (wb[k] != 8'(baddr(bw_r, bw_c, k))) win_err_b++;
      if (bw_c == BW - 2) begin
        bw_c = 1;
        bw_r = (bw_r == BH - 2) ? 1 : bw_r + 1;
      end else bw_c++;
    end
  end

  // -------------------------------------------------------------- helpers
  function automatic logic any_out_a();
    logic v;
    v = rd_en_a | (|rd_addr_a) | (|win_row_a) | (|win_col_a) | win_valid_a | busy_a | halt_a;
    for (int k = 0; k < 9; k++) v = v | (|wa[k]);
    return v;
  endfunction

  function automatic logic any_out_b();
    logic v;
    v = rd_en_b | (|rd_addr_b) | (|win_row_b) | (|win_col_b) | win_valid_b | busy_b | halt_b;
    for (int k = 0; k < 9; k++) v = v | (|wb[k]);
    return v;
  endfunction

  // Pulse start_a across one rising edge (the entry edge E).
  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  // Count rising edges from the current edge until win_valid_a is seen.
  task automatic wait_valid_a(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!win_valid_a && n < 40);
  endtask

  // --------------------------------------------------------- vector table
  typedef struct {
    int         stall;
    logic [9:0] row;
    logic [9:0] col;
    logic [7:0] win [9];
    logic       is_last;
  } vec_t;

  vec_t vecs [4];

  // ----------------------------------------------------------------- main
  initial begin
    int n, errs, rd0, q0, h0, hs0, rdb0, ab0, wb0;

    reset_a = 1'b0; start_a = 1'b0; ready_a = 1'b0;
    reset_b = 1'b0; start_b = 1'b0; ready_b = 1'b1;

    vecs[0] = '{stall: 0,  row: 10'd1, col: 10'd1,
                win: '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}, is_last: 1'b0};
    vecs[1] = '{stall: 50, row: 10'd1, col: 10'd2,
                win: '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}, is_last: 1'b0};
    vecs[2] = '{stall: 3,  row: 10'd2, col: 10'd1,
                win: '{8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}, is_last: 1'b0};
    vecs[3] = '{stall: 0,  row: 10'd2, col: 10'd2,
                win: '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}, is_last: 1'b1};

    // Reset with the clock running.
    #23;
    check("reset_outputs_a", 32'(any_out_a()), 32'd0);
    check("reset_outputs_b", 32'(any_out_b()), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", 32'(any_out_a()), 32'd0);

    // ---- table pass: one window per record, stalls and start-while-busy
    rd0 = rd_cnt_a;
    q0  = qa.size();
    pulse_start_a();
    check("entry_rd_en", 32'(rd_en_a), 32'd1);
    check("entry_addr", 32'(rd_addr_a), 32'd0);
    check("entry_busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      int rs;
      wait_valid_a(n);
      check($sformatf("latency_w%0d", i), n, 32'd10);
      rs = rd_cnt_a;
      for (int s = 0; s < vecs[i].stall; s++) begin
        @(negedge clk);
        if (s == 10) start_a = 1'b1;
        if (s == 11) start_a = 1'b0;
      end
      check($sformatf("stall_no_reads_w%0d", i), rd_cnt_a - rs, 32'd0);
      check($sformatf("valid_w%0d", i), 32'(win_valid_a), 32'd1);
      check($sformatf("busy_w%0d", i), 32'(busy_a), 32'd1);
      check($sformatf("row_w%0d", i), 32'(win_row_a), 32'(vecs[i].row));
      check($sformatf("col_w%0d", i), 32'(win_col_a), 32'(vecs[i].col));
      errs = 0;
      for (int k = 0; k < 9; k++) if (wa[k] !== vecs[i].win[k]) errs++;
      check($sformatf("win_bad_bytes_w%0d", i), errs, 32'd0);

      @(negedge clk) ready_a = 1'b1;
      @(posedge clk);
      #1 ready_a = 1'b0;
      check($sformatf("valid_drop_w%0d", i), 32'(win_valid_a), 32'd0);
      if (vecs[i].is_last) begin
        check("done_halt", 32'(halt_a), 32'd1);
        check("done_busy", 32'(busy_a), 32'd0);
        check("done_rd_en", 32'(rd_en_a), 32'd0);
      end else begin
        check($sformatf("refetch_rd_en_w%0d", i), 32'(rd_en_a), 32'd1);
        check($sformatf("refetch_base_w%0d", i), 32'(rd_addr_a),
              32'((int'(vecs[i+1].row) - 1) * AW + int'(vecs[i+1].col) - 1));
      end
    end
    check("frame_read_count", rd_cnt_a - rd0, 32'd36);
    errs = 0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 9; k++)
        if (int'(qa[q0 + i*9 + k]) != (int'(vecs[i].row) - 1 + k/3) * AW + int'(vecs[i].col) - 1 + k%3)
          errs++;
    check("frame_addr_seq_errors", errs, 32'd0);
    repeat (5) @(negedge clk);
    check("done_persists", 32'(halt_a), 32'd1);
    check("done_stays_quiet", rd_cnt_a - rd0, 32'd36);

    // ---- restart from DONE with win_ready tied high
    rd0 = rd_cnt_a;
    h0  = hs_r.size();
    ready_a = 1'b1;
    pulse_start_a();
    check("restart_halt_clear", 32'(halt_a), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!halt_a && n < 100);
    check("tied_frame_edges", n, 32'd44);
    check("tied_handshakes", hs_r.size() - h0, 32'd4);
    errs = 0;
    for (int i = 0; i < 4 && h0 + i < hs_r.size(); i++)
      if (hs_r[h0+i] != int'(vecs[i].row) || hs_c[h0+i] != int'(vecs[i].col)) errs++;
    check("tied_window_order_errors", errs, 32'd0);
    check("tied_read_count", rd_cnt_a - rd0, 32'd36);
    ready_a = 1'b0;

    // ---- reset during the 5th read of the 2nd window
    pulse_start_a();
    wait_valid_a(n);
    @(negedge clk) ready_a = 1'b1;
    @(posedge clk);                 // handshake edge, re-enters FETCH
    #1 ready_a = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("k4_rd_en", 32'(rd_en_a), 32'd1);
    check("k4_addr", 32'(rd_addr_a), 32'd6);
    #2 reset_a = 1'b0;
    #1;
    check("async_reset_outputs", 32'(any_out_a()), 32'd0);
    repeat (2) @(negedge clk);
    reset_a = 1'b1;
    rd0 = rd_cnt_a;
    repeat (6) @(negedge clk);
    check("post_reset_idle", 32'(any_out_a()), 32'd0);
    check("post_reset_no_reads", rd_cnt_a - rd0, 32'd0);
    pulse_start_a();
    wait_valid_a(n);
    check("post_reset_latency", n, 32'd10);
    check("post_reset_row", 32'(win_row_a), 32'd1);
    check("post_reset_col", 32'(win_col_a), 32'd1);
    errs = 0;
    for (int k = 0; k < 9; k++) if (wa[k] !== vecs[0].win[k]) errs++;
    check("post_reset_win_bad_bytes", errs, 32'd0);

    // ---- 800-wide frame, two passes
    for (int pass = 0; pass < 2; pass++) begin
      rdb0 = rd_cnt_b; hs0 = hs_cnt_b; ab0 = addr_err_b; wb0 = win_err_b;
      @(negedge clk) start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      n = 0;
      do begin
        @(posedge clk);
        n++;
        #1;
      end while (!halt_b && n < 20000);
      check($sformatf("b%0d_frame_edges", pass), n, 32'(B_WINS * 11));
      check($sformatf("b%0d_halt", pass), 32'(halt_b), 32'd1);
      check($sformatf("b%0d_busy", pass), 32'(busy_b), 32'd0);
      check($sformatf("b%0d_handshakes", pass), hs_cnt_b - hs0, 32'(B_WINS));
      check($sformatf("b%0d_reads", pass), rd_cnt_b - rdb0, 32'(B_WINS * 9));
      check($sformatf("b%0d_addr_errors", pass), addr_err_b - ab0, 32'd0);
      check($sformatf("b%0d_win_errors", pass), win_err_b - wb0, 32'd0);
      check($sformatf("b%0d_last_addr", pass), last_addr_b, 32'(BW * BH - 1));
      check($sformatf("b%0d_last_row", pass), 32'(win_row_b), 32'(BH - 2));
      check($sformatf("b%0d_last_col", pass), 32'(win_col_b), 32'(BW - 2));
      check($sformatf("b%0d_addr_hold", pass), 32'(rd_addr_b), 32'(BW * BH - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
